// File: rtl/flag_pkg.sv
// Shared definitions for the condition-flag writer: FSM states and bit positions
// within the {N,Z,C,V} flag word and the FlagW write-enable field.
package flag_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/flag_gen.sv
// Combinational flag generation from the ALU result and adder/shifter carries.
import flag_pkg::*;

module flag_gen (
    input  logic [31:0] i_result,
    input  logic        i_alu_carry,
    input  logic        i_alu_overflow,
    input  logic        i_sh_carry,
    input  logic        i_alu_arith,
    input  logic        i_flag_v_prev,
    output logic [3:0]  o_flags
);

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = i_result[31];
        o_flags[FLAG_Z] = (i_result == '0);
        o_flags[FLAG_C] = i_alu_arith ? i_alu_carry    : i_sh_carry;
        // Logical ops have no overflow concept, so V carries the previous value.
        o_flags[FLAG_V] = i_alu_arith ? i_alu_overflow : i_flag_v_prev;
    end

endmodule

// File: rtl/flag_writer.sv
// Flag register with a single-level shadow copy saved on exception entry
// and restored on exception return.
import flag_pkg::*;

module flag_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Result,
    input  logic        ALUCarry,
    input  logic        ALUOverflow,
    input  logic        ShCarry,
    input  logic        ALUArith,
    input  logic [1:0]  FlagW,
    input  logic        CondEx,
    input  logic        ExcEntry,
    input  logic        ExcReturn,
    output logic [3:0]  Flags,
    output logic [3:0]  FlagsNext,
    output logic [3:0]  SavedFlags,
    output logic        ExcAck,
    output logic        Busy
);

    state_t     r_state;
    logic [3:0] r_flags;
    logic [3:0] r_saved;
    logic       r_saved_valid;

    state_t     w_state_d;
    logic [3:0] w_gen;
    logic [3:0] w_flags_d;
    logic [3:0] w_saved_d;
    logic       w_saved_valid_d;

    flag_gen u_flag_gen (
        .i_result       (Result),
        .i_alu_carry    (ALUCarry),
        .i_alu_overflow (ALUOverflow),
        .i_sh_carry     (ShCarry),
        .i_alu_arith    (ALUArith),
        .i_flag_v_prev  (r_flags[FLAG_V]),
        .o_flags        (w_gen)
    );

    always_comb begin
        w_state_d       = r_state;
        w_flags_d       = r_flags;
        w_saved_d       = r_saved;
        w_saved_valid_d = r_saved_valid;
        unique case (r_state)
            IDLE: begin
                // The ALU write lands on the same edge that enters SAVE, so the
                // saved copy sees it.
                if (CondEx) begin
                    if (FlagW[FW_NZ]) begin
                        w_flags_d[FLAG_N] = w_gen[FLAG_N];
                        w_flags_d[FLAG_Z] = w_gen[FLAG_Z];
                    end
                    if (FlagW[FW_CV]) begin
                        w_flags_d[FLAG_C] = w_gen[FLAG_C];
                        w_flags_d[FLAG_V] = w_gen[FLAG_V];
                    end
                end
                if (ExcEntry)
                    w_state_d = SAVE;
                else if (ExcReturn)
                    w_state_d = RESTORE;
            end
            SAVE: begin
                w_saved_d       = r_flags;
                w_saved_valid_d = 1'b1;
                w_state_d       = IDLE;
            end
            RESTORE: begin
                if (r_saved_valid) begin
                    w_flags_d       = r_saved;
                    w_saved_valid_d = 1'b0;
                end
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_flags       <= '0;
            r_saved       <= '0;
            r_saved_valid <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_flags       <= w_flags_d;
            r_saved       <= w_saved_d;
            r_saved_valid <= w_saved_valid_d;
        end
    end

    assign Flags      = r_flags;
    assign FlagsNext  = w_flags_d;
    assign SavedFlags = r_saved;
    assign ExcAck     = (r_state == SAVE) || (r_state == RESTORE);
    assign Busy       = (r_state == SAVE) || (r_state == RESTORE);

endmodule

// File: tb/tb_flag_writer.sv
// Directed bench for flag_writer: a transaction-level model checked every cycle
// plus literal expectations for the documented scenarios.
module tb_flag_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Result;
    logic        ALUCarry, ALUOverflow, ShCarry, ALUArith;
    logic [1:0]  FlagW;
    logic        CondEx, ExcEntry, ExcReturn;
    logic [3:0]  Flags, FlagsNext, SavedFlags;
    logic        ExcAck, Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    flag_writer dut (
        .clk         (clk),
        .reset       (reset),
        .Result      (Result),
        .ALUCarry    (ALUCarry),
        .ALUOverflow (ALUOverflow),
        .ShCarry     (ShCarry),
        .ALUArith    (ALUArith),
        .FlagW       (FlagW),
        .CondEx      (CondEx),
        .ExcEntry    (ExcEntry),
        .ExcReturn   (ExcReturn),
        .Flags       (Flags),
        .FlagsNext   (FlagsNext),
        .SavedFlags  (SavedFlags),
        .ExcAck      (ExcAck),
        .Busy        (Busy)
    );

    always #5 clk = ~clk;

    // Model: flags, shadow, validity, and the exception operation (if any)
    // being serviced this cycle: 0 none, 1 save, 2 restore.
    logic [3:0] m_flags = '0;
    logic [3:0] m_saved = '0;
    logic       m_valid = 1'b0;
    int         m_op    = 0;
    bit         started = 1'b0;

    function automatic logic [3:0] model_next();
        logic [3:0] f;
        logic n, z, c, v;
        f = m_flags;
        if (m_op == 2) begin
            if (m_valid) f = m_saved;
        end else if (m_op == 0 && CondEx) begin
            n = Result[31];
            z = (Result == 32'd0);
            c = ALUArith ? ALUCarry : ShCarry;
            v = ALUArith ? ALUOverflow : m_flags[0];
            if (FlagW[1]) f[3:2] = {n, z};
            if (FlagW[0]) f[1:0] = {c, v};
        end
        return f;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_flags = '0; m_saved = '0; m_valid = 1'b0; m_op = 0;
        end else if (m_op == 1) begin
            m_saved = m_flags; m_valid = 1'b1; m_op = 0;
        end else if (m_op == 2) begin
            m_flags = model_next();
            if (m_valid) m_valid = 1'b0;
            m_op = 0;
        end else begin
            m_flags = model_next();
            m_op = ExcEntry ? 1 : (ExcReturn ? 2 : 0);
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model.Flags",      Flags,             m_flags);
            chk("model.SavedFlags", SavedFlags,        m_saved);
            chk("model.ExcAck",     {3'b0, ExcAck},    {3'b0, m_op != 0});
            chk("model.Busy",       {3'b0, Busy},      {3'b0, m_op != 0});
            if (!reset) chk("model.FlagsNext", FlagsNext, model_next());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [31:0] res, input logic arith, input logic cy,
                       input logic ov, input logic sh, input logic [1:0] fw, input logic ce);
        Result = res; ALUArith = arith; ALUCarry = cy; ALUOverflow = ov;
        ShCarry = sh; FlagW = fw; CondEx = ce;
    endtask

    initial begin
        reset = 1'b1; ExcEntry = 1'b0; ExcReturn = 1'b0;
        alu(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(); tick();
        chk("reset.Flags", Flags, 4'b0000);
        chk("reset.Saved", SavedFlags, 4'b0000);
        chk("reset.AckBusy", {2'b0, ExcAck, Busy}, 4'b0000);
        reset = 1'b0;

        // Arithmetic zero result with carry.
        alu(32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
        tick();
        chk("arith.zero", Flags, 4'b0110);

        // Set 1001, then a logical op keeps V.
        alu(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1);
        tick();
        chk("set.1001", Flags, 4'b1001);
        alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        tick();
        chk("logic.vhold", Flags, 4'b1011);
        alu(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1);
        tick();
        alu(32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        chk("condex0.hold", Flags, 4'b1001);
        alu(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        chk("flagw00.hold", Flags, 4'b1001);
        alu(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1);
        tick();
        chk("flagw01.cv_only", Flags, 4'b1010);

        // Save with a same-cycle N,Z write.
        alu(32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
        tick();
        chk("set.0010", Flags, 4'b0010);
        alu(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        ExcEntry = 1'b1;
        tick();
        chk("save.ack", {2'b0, ExcAck, Busy}, 4'b0011);
        chk("save.flags", Flags, 4'b0110);
        ExcEntry = 1'b0; FlagW = 2'b00;
        tick();
        chk("save.shadow", SavedFlags, 4'b0110);
        chk("save.ackdone", {3'b0, ExcAck}, 4'b0000);

        // Restore, then a second restore with nothing valid.
        alu(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
        tick();
        chk("set.1000", Flags, 4'b1000);
        FlagW = 2'b00; ExcReturn = 1'b1;
        tick();
        chk("restore.ack", {3'b0, ExcAck}, 4'b0001);
        ExcReturn = 1'b0;
        tick();
        chk("restore.flags", Flags, 4'b0110);
        alu(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1);
        tick();
        FlagW = 2'b00; ExcReturn = 1'b1;
        tick();
        chk("restore2.ack", {3'b0, ExcAck}, 4'b0001);
        ExcReturn = 1'b0;
        tick();
        chk("restore2.hold", Flags, 4'b1000);

        // Both requests: save wins, writes during SAVE dropped, Busy one cycle.
        ExcEntry = 1'b1; ExcReturn = 1'b1;
        tick();
        chk("both.busy1", {3'b0, Busy}, 4'b0001);
        ExcEntry = 1'b0; ExcReturn = 1'b0;
        alu(32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
        tick();
        chk("both.busy0", {3'b0, Busy}, 4'b0000);
        chk("both.dropped", Flags, 4'b1000);
        chk("both.saved", SavedFlags, 4'b1000);
        FlagW = 2'b00;

        // Request held past ExcAck re-enters SAVE.
        ExcEntry = 1'b1;
        tick(); tick(); tick();
        chk("held.reenter", {3'b0, Busy}, 4'b0001);
        ExcEntry = 1'b0;
        tick();

        // Reset during SAVE aborts it.
        ExcEntry = 1'b1;
        tick();
        chk("rst.insave", {3'b0, Busy}, 4'b0001);
        reset = 1'b1; ExcEntry = 1'b0;
        tick();
        chk("rst.ack", {3'b0, ExcAck}, 4'b0000);
        chk("rst.flags", Flags, 4'b0000);
        chk("rst.saved", SavedFlags, 4'b0000);
        reset = 1'b0;
        alu(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
        tick();
        FlagW = 2'b00; ExcReturn = 1'b1;
        tick();
        ExcReturn = 1'b0;
        tick();
        chk("rst.novalid", Flags, 4'b0110);

        // Mixed ALU traffic checked by the model.
        for (int i = 0; i < 40; i++) begin
            alu($urandom_range(3) == 0 ? 32'd0 : $urandom, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            ExcEntry  = ($urandom_range(7) == 0);
            ExcReturn = ($urandom_range(7) == 0);
            tick();
        end
        ExcEntry = 1'b0; ExcReturn = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_writer.md
FLAG_WRITER -- requirements
Module: flag_writer

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset, with ports clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Result  in  32  ALU result for the executing instruction.
REQ-005 ALUCarry  in  1  adder carry-out.
REQ-006 ALUOverflow  in  1  adder signed overflow.
REQ-007 ShCarry  in  1  shifter carry-out, used for logical ops.
REQ-008 ALUArith  in  1  1 = add/sub (C,V from adder); 0 = logical op.
REQ-009 FlagW  in  2  bit1 = write N,Z; bit0 = write C,V.
REQ-010 CondEx  in  1  instruction condition passed; gates all flag writes.
REQ-011 ExcEntry  in  1  request to save the flags on exception entry; level, held until ExcAck.
REQ-012 ExcReturn  in  1  request to restore the flags on exception return; level, held until ExcAck.
REQ-013 Flags  out  4  registered {N,Z,C,V}; read by the condition checker.
REQ-014 FlagsNext  out  4  combinational value Flags will take at the next edge (bypass).
REQ-015 SavedFlags  out  4  shadow flag register.
REQ-016 ExcAck  out  1  one-cycle pulse on completion of a save or restore.
REQ-017 Busy  out  1  high while in state SAVE or RESTORE; ALU flag writes are dropped.

Function
REQ-018 Generated flags SHALL be: N = Result[31]; Z = (Result == 0); C = ALUArith ? ALUCarry : ShCarry; V = ALUArith ? ALUOverflow : Flags.V.
REQ-019 In IDLE with CondEx=1, FlagW[1] SHALL load N,Z and FlagW[0] SHALL load C,V at the next edge; unselected bits hold.
REQ-020 CondEx=0 or FlagW=00 SHALL leave Flags unchanged.
REQ-021 FSM states SHALL be IDLE, SAVE, RESTORE.
REQ-022 IDLE→SAVE when ExcEntry=1; IDLE→RESTORE when ExcReturn=1 and ExcEntry=0; ExcEntry wins when both are asserted.
REQ-023 An ALU write in the same IDLE cycle as a request SHALL still complete, so SAVE captures the updated Flags.
REQ-024 SAVE (one cycle): SavedFlags ← Flags, SavedValid ← 1, ExcAck=1, then →IDLE.
REQ-025 RESTORE (one cycle): if SavedValid=1 then Flags ← SavedFlags and SavedValid ← 0; otherwise Flags are unchanged. ExcAck=1 in both cases, then →IDLE.
REQ-026 In SAVE/RESTORE, FlagW/CondEx SHALL be ignored; the requester SHALL deassert its request in the cycle after ExcAck, and any request still high re-enters the FSM.
REQ-027 A second save without an intervening restore SHALL overwrite SavedFlags (single-level shadow).
REQ-028 FlagsNext SHALL equal the D-input of the Flags register in every state.
REQ-029 ExcAck and Busy SHALL be decoded from state and SHALL be glitch-free registered-state outputs.

Reset
REQ-030 reset SHALL force: state IDLE, Flags=0000, SavedFlags=0000, SavedValid=0, ExcAck=0, Busy=0.
REQ-031 reset asserted mid-SAVE/RESTORE SHALL abort the operation with no ExcAck and reset values applied at that edge.
REQ-032 reset SHALL take priority over every write, save and restore.

Structure
REQ-033 Package flag_pkg SHALL hold the state enum (IDLE, SAVE, RESTORE), flag bit indices N=3, Z=2, C=1, V=0, and FlagW bit positions NZ=1, CV=0.
REQ-034 Flag computation (REQ-018) SHALL be one combinational sub-module flag_gen; the registers and FSM live in flag_writer.

Verification
REQ-035 Result=0, ALUArith=1, ALUCarry=1, FlagW=11, CondEx=1 -> next cycle Flags=0110.
REQ-036 Flags=1001, logical op with Result=0x8000_0000, ShCarry=1, FlagW=11 -> Flags=1011 (V held); the same op with CondEx=0 -> Flags stay 1001.
REQ-037 Flags=0010, ExcEntry high with a same-cycle write of N,Z from Result=0 -> SAVE next cycle, ExcAck pulse, SavedFlags=0110.
REQ-038 Flags changed to 1000 after a save of 0110, ExcReturn -> ExcAck pulse, Flags=0110, SavedValid=0; a second ExcReturn -> ExcAck with Flags unchanged.
REQ-039 ExcEntry and ExcReturn asserted together -> SAVE taken; FlagW=11 during SAVE is dropped; Busy=1 for exactly one cycle.
REQ-040 reset asserted during SAVE -> no ExcAck, Flags=SavedFlags=0000, state IDLE.
